// File: rtl/core_mdu_iter_if.sv
// Handshake and operand bundle between the execution stage and the
// iterative multiply/divide unit.
interface core_mdu_iter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  mdu_start;
  logic [2:0]            mdu_control;
  logic [DATA_WIDTH-1:0] mdu_in_a;
  logic [DATA_WIDTH-1:0] mdu_in_b;
  logic                  mdu_flush;
  logic                  mdu_ready;
  logic                  mdu_busy;
  logic                  mdu_valid;
  logic [DATA_WIDTH-1:0] mdu_out;

  modport master (
    output mdu_start, mdu_control, mdu_in_a, mdu_in_b, mdu_flush,
    input  mdu_ready, mdu_busy, mdu_valid, mdu_out
  );

  modport slave (
    input  mdu_start, mdu_control, mdu_in_a, mdu_in_b, mdu_flush,
    output mdu_ready, mdu_busy, mdu_valid, mdu_out
  );
endinterface

// File: rtl/core_mdu_iter.sv
// Radix-2 iterative RV32M multiply/divide unit: one shift-add or restoring
// step per clock on operand magnitudes, sign fix-up folded into the final step.
module core_mdu_iter #(
  parameter int DATA_WIDTH = 32,
  parameter bit EARLY_OUT  = 1'b1
) (
  input logic            clk,
  input logic            rst,
  core_mdu_iter_if.slave mdu
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [W-1:0]     MIN_VAL  = {1'b1, {(W-1){1'b0}}};

  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [W-1:0]     out_q, out_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;

  logic [2:0]   ctl;
  logic [W-1:0] in_a, in_b;
  logic         a_sgn, b_sgn, a_neg, b_neg, b_zero, is_special, start_neg;

  logic [W:0]   mul_sum, div_sh;
  logic         div_ge;
  logic [W-1:0] step_hi, step_lo;

  function automatic logic [W-1:0] mag_f(input logic [W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Apply the deferred sign and pick the half/register the op returns.
  function automatic logic [W-1:0] result_f(input logic [2:0] op, input logic neg,
                                            input logic [W-1:0] hi, input logic [W-1:0] lo);
    logic [2*W-1:0] prod;
    logic [W-1:0]   res;
    prod = neg ? -{hi, lo} : {hi, lo};
    if (!op[2]) begin
      res = (op[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
    end else if (op[1]) begin
      res = neg ? -hi : hi;
    end else begin
      res = neg ? -lo : lo;
    end
    return res;
  endfunction

  function automatic logic [W-1:0] special_f(input logic [2:0] op,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] res;
    if (b == '0) begin
      res = op[1] ? a : '1;
    end else begin
      res = op[1] ? '0 : MIN_VAL;
    end
    return res;
  endfunction

  assign ctl  = mdu.mdu_control;
  assign in_a = mdu.mdu_in_a;
  assign in_b = mdu.mdu_in_b;

  always_comb begin
    a_sgn  = (ctl == OP_MULH) || (ctl == OP_MULHSU) || (ctl == OP_DIV) || (ctl == OP_REM);
    b_sgn  = (ctl == OP_MULH) || (ctl == OP_DIV) || (ctl == OP_REM);
    a_neg  = a_sgn & in_a[W-1];
    b_neg  = b_sgn & in_b[W-1];
    b_zero = (in_b == '0);
    is_special = ctl[2] & (b_zero | (~ctl[0] & (in_a == MIN_VAL) & (in_b == '1)));
    // Divide-by-zero keeps an all-ones quotient, so its sign fix-up is masked.
    if (!ctl[2]) begin
      start_neg = a_neg ^ b_neg;
    end else if (ctl[1]) begin
      start_neg = a_neg;
    end else begin
      start_neg = (a_neg ^ b_neg) & ~b_zero;
    end
  end

  // Single iteration: hi:lo is the product accumulator or remainder:quotient.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
    div_sh  = {hi_q, lo_q[W-1]};
    div_ge  = (div_sh >= {1'b0, opb_q});
    if (op_q[2]) begin
      step_hi = div_ge ? W'(div_sh - {1'b0, opb_q}) : div_sh[W-1:0];
      step_lo = {lo_q[W-2:0], div_ge};
    end else begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], lo_q[W-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    op_d    = op_q;
    neg_d   = neg_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (mdu.mdu_start) begin
          op_d    = ctl;
          neg_d   = start_neg;
          hi_d    = '0;
          lo_d    = mag_f(in_a, a_neg);
          opb_d   = mag_f(in_b, b_neg);
          cnt_d   = CNT_LOAD;
          state_d = S_BUSY;
          if (EARLY_OUT && is_special) begin
            cnt_d   = '0;
            out_d   = special_f(ctl, in_a, in_b);
            state_d = S_DONE;
          end
        end
      end
      S_BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          out_d   = result_f(op_q, neg_q, step_hi, step_lo);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (mdu.mdu_flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      out_d   = out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      out_q   <= out_d;
    end
  end

  assign mdu.mdu_ready = (state_q == S_IDLE);
  assign mdu.mdu_busy  = (state_q != S_IDLE);
  assign mdu.mdu_valid = (state_q == S_DONE);
  assign mdu.mdu_out   = out_q;

endmodule
